// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS memory-access stage: access sizes,
// byte-lane masks and load extraction/extension.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    localparam logic [3:0] LANE_BYTE0   = 4'b0001;
    localparam logic [3:0] LANE_HALF_LO = 4'b0011;
    localparam logic [3:0] LANE_HALF_HI = 4'b1100;
    localparam logic [3:0] LANE_WORD    = 4'b1111;

    // The reserved encoding 3 behaves as a word access.
    function automatic mem_size_t decode_size(input logic [1:0] raw);
        case (raw)
            2'd0:    return SZ_BYTE;
            2'd1:    return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input mem_size_t   size,
                                                 input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: return is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port data memory: four byte lanes with independent synchronous write
// enables and an asynchronous read of the addressed word.
module dmem_bram #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [3:0]                     byte_en_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (byte_en_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: byte-enabled data memory plus the MEM/WB pipeline register.
// Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses via wb_exc.
module mem_stage
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_unsigned,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        wb_exc
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic          accept;
    mem_size_t     size;
    logic [1:0]    lane;
    logic          misaligned;
    logic [3:0]    laneMask;
    logic [3:0]    byteEn;
    logic [31:0]   storeData;
    logic [31:0]   rdata;
    logic [31:0]   loadData;
    logic [AW-1:0] wordIdx;

    logic          valid_q, valid_d;
    logic [4:0]    rd_q, rd_d;
    logic          regWrite_q, regWrite_d;
    logic [31:0]   data_q, data_d;
    logic          exc_d;

    assign accept  = ex_valid & ~stall & ~reset;
    assign size    = decode_size(ex_mem_size);
    assign wordIdx = ex_alu_result[AW+1:2];

    // Without the alignment trap, low address bits below the access size are dropped.
    always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
        lane       = ex_alu_result[1:0];
        misaligned = (ex_mem_read | ex_mem_write) &
                     (((size == SZ_HALF) & ex_alu_result[0]) |
                      ((size == SZ_WORD) & (|ex_alu_result[1:0])));
`else
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: lane = ex_alu_result[1:0];
            SZ_HALF: lane = {ex_alu_result[1], 1'b0};
            default: lane = 2'b00;
        endcase
`endif
    end

    always_comb begin
        laneMask  = LANE_WORD;
        storeData = ex_store_data;
        case (size)
            SZ_BYTE: begin
                laneMask  = LANE_BYTE0 << lane;
                storeData = {4{ex_store_data[7:0]}};
            end
            SZ_HALF: begin
                laneMask  = lane[1] ? LANE_HALF_HI : LANE_HALF_LO;
                storeData = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign byteEn   = (accept & ex_mem_write & ~misaligned) ? laneMask : 4'b0000;
    assign loadData = load_extract(rdata, lane, size, ex_mem_unsigned);

    dmem_bram #(.DEPTH_WORDS(DEPTH_WORDS)) u_dmem (
        .clk      (clk),
        .addr_i   (wordIdx),
        .byte_en_i(byteEn),
        .wdata_i  (storeData),
        .rdata_o  (rdata)
    );

    // A store that also claims to be a load keeps the store and drops the load.
    always_comb begin
        valid_d    = valid_q;
        rd_d       = rd_q;
        regWrite_d = regWrite_q;
        data_d     = data_q;
        exc_d      = wb_exc;
        if (!stall) begin
            if (ex_valid) begin
                valid_d    = 1'b1;
                rd_d       = ex_rd;
                regWrite_d = ex_reg_write & (ex_rd != 5'd0) & ~ex_mem_write & ~misaligned;
                data_d     = (ex_mem_read & ~ex_mem_write & ~misaligned) ? loadData : ex_alu_result;
                exc_d      = misaligned;
            end else begin
                valid_d    = 1'b0;
                regWrite_d = 1'b0;
                exc_d      = 1'b0;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic exc_q;
    always_ff @(posedge clk) begin
        if (reset) exc_q <= 1'b0;
        else       exc_q <= exc_d;
    end
    assign wb_exc = exc_q;
`else
    assign wb_exc = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            rd_q       <= 5'd0;
            regWrite_q <= 1'b0;
            data_q     <= 32'd0;
        end else begin
            valid_q    <= valid_d;
            rd_q       <= rd_d;
            regWrite_q <= regWrite_d;
            data_q     <= data_d;
        end
    end

    assign wb_valid     = valid_q;
    assign wb_rd        = rd_q;
    assign wb_reg_write = regWrite_q;
    assign wb_data      = data_q;

endmodule
